// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the 16-bit register/ALU datapath.
// Define CPU_BRANCH_EN to enable conditional branches on opcode 001.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mdata,
    input  logic [15:0] datapath_out,
    input  logic [2:0]  status_in,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic [1:0]  vsel,
    output logic [1:0]  asel,
    output logic [1:0]  bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic [7:0]  PC,
    output logic [1:0]  mem_cmd,
    output logic [7:0]  mem_addr,
    output logic        halted
);
    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPD, S_DEC,
        S_WIMM, S_GA, S_GB, S_EX, S_WR,
        S_AD, S_LA, S_MR1, S_MR2,
        S_GB2, S_PS, S_MW, S_HALT,
        S_BC, S_BL
    } state_t;

    state_t state, next;
    logic [15:0] ir;
    logic [7:0]  pc, daddr;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    logic mov_imm, mov_reg, is_alu, is_cmp, is_mvn, is_ldr, is_str;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign PC     = pc;

    // Only the low byte of C ever addresses memory or loads the PC.
    logic unused_dp_hi;
    assign unused_dp_hi = ^datapath_out[15:8];

`ifdef CPU_BRANCH_EN
    logic is_br, br_legal, br_take;
    logic flag_z, flag_v, flag_n;
    assign flag_z   = status_in[2];
    assign flag_v   = status_in[1];
    assign flag_n   = status_in[0];
    assign is_br    = (opcode == 3'b001);
    assign br_legal = (rn <= 3'd4);
    always_comb begin
        br_take = 1'b0;
        unique case (rn)
            3'd0:    br_take = 1'b1;
            3'd1:    br_take = flag_z;
            3'd2:    br_take = !flag_z;
            3'd3:    br_take = flag_n ^ flag_v;
            3'd4:    br_take = (flag_n ^ flag_v) | flag_z;
            default: br_take = 1'b0;
        endcase
    end
`else
    logic unused_status;
    assign unused_status = ^status_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_RST;
        else       state <= next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= 8'h00;
            ir    <= 16'h0000;
            daddr <= 8'h00;
        end else begin
            case (state)
                S_IF2:   ir    <= mdata;
                S_UPD:   pc    <= pc + 8'd1;
                S_LA:    daddr <= datapath_out[7:0];
`ifdef CPU_BRANCH_EN
                S_BL:    pc    <= datapath_out[7:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_RST:  next = S_IF1;
            S_IF1:  next = S_IF2;
            S_IF2:  next = S_UPD;
            S_UPD:  next = S_DEC;
            S_DEC: begin
                unique case (1'b1)
                    mov_imm:                   next = S_WIMM;
                    mov_reg || is_mvn:         next = S_GB;
                    is_alu && !is_mvn:         next = S_GA;
                    is_ldr || is_str:          next = S_GA;
`ifdef CPU_BRANCH_EN
                    is_br && br_legal:         next = br_take ? S_BC : S_IF1;
`endif
                    default:                   next = S_HALT;
                endcase
            end
            S_WIMM: next = S_IF1;
            S_GA:   next = is_alu ? S_GB : S_AD;
            S_GB:   next = S_EX;
            S_EX:   next = is_cmp ? S_IF1 : S_WR;
            S_WR:   next = S_IF1;
            S_AD:   next = S_LA;
            S_LA:   next = is_str ? S_GB2 : S_MR1;
            S_MR1:  next = S_MR2;
            S_MR2:  next = S_IF1;
            S_GB2:  next = S_PS;
            S_PS:   next = S_MW;
            S_MW:   next = S_IF1;
            S_HALT: next = S_HALT;
`ifdef CPU_BRANCH_EN
            S_BC:   next = S_BL;
            S_BL:   next = S_IF1;
`endif
            default: next = S_HALT;
        endcase
    end

    always_comb begin
        readnum  = 3'd0;
        writenum = 3'd0;
        vsel     = 2'b00;
        asel     = 2'b00;
        bsel     = 2'b00;
        ALUop    = 2'b00;
        shift    = 2'b00;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        mem_cmd  = CMD_NONE;
        mem_addr = pc;
        halted   = 1'b0;
        case (state)
            S_IF1, S_IF2: mem_cmd = CMD_READ;
            S_WIMM: begin
                vsel     = 2'b10;
                writenum = rn;
                write    = 1'b1;
            end
            S_GA: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GB: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_EX: begin
                shift = sh;
                ALUop = is_alu ? op : 2'b00;
                asel  = mov_reg ? 2'b01 : 2'b00;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            S_WR: begin
                writenum = rd;
                write    = 1'b1;
            end
            S_AD: begin
                bsel  = 2'b01;
                loadc = 1'b1;
            end
            S_MR1: begin
                mem_cmd  = CMD_READ;
                mem_addr = daddr;
            end
            S_MR2: begin
                mem_cmd  = CMD_READ;
                mem_addr = daddr;
                vsel     = 2'b01;
                writenum = rd;
                write    = 1'b1;
            end
            S_GB2: begin
                readnum = rd;
                loadb   = 1'b1;
            end
            S_PS: begin
                asel  = 2'b01;
                loadc = 1'b1;
            end
            S_MW: begin
                mem_cmd  = CMD_WRITE;
                mem_addr = daddr;
            end
            S_HALT: halted = 1'b1;
`ifdef CPU_BRANCH_EN
            S_BC: begin
                asel  = 2'b10;
                bsel  = 2'b10;
                loadc = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed instruction table, reset/halt
// sequences and random programs checked against a per-instruction model.
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic [15:0] mdata;
    logic [15:0] datapath_out;
    logic [2:0]  status_in;
    logic [2:0]  readnum, writenum;
    logic [1:0]  vsel, asel, bsel, ALUop, shift;
    logic        loada, loadb, loadc, loads, write;
    logic [15:0] sximm8, sximm5;
    logic [7:0]  PC;
    logic [1:0]  mem_cmd;
    logic [7:0]  mem_addr;
    logic        halted;

    cpu_controller dut (
        .clk(clk), .reset(reset), .mdata(mdata),
        .datapath_out(datapath_out), .status_in(status_in),
        .readnum(readnum), .writenum(writenum),
        .vsel(vsel), .asel(asel), .bsel(bsel),
        .ALUop(ALUop), .shift(shift),
        .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .write(write),
        .sximm8(sximm8), .sximm5(sximm5), .PC(PC),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .halted(halted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic [1:0] vsel;
        logic [1:0] asel;
        logic [1:0] bsel;
        logic [1:0] aluop;
        logic [1:0] shift;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic [1:0] mem_cmd;
        logic [7:0] mem_addr;
        logic       halted;
        logic [7:0] pc;
    } cyc_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] dp;
        logic [2:0]  st;
        int          cycles;
        logic [7:0]  npc;
    } vec_t;

    localparam logic [1:0] RD = 2'b01;
    localparam logic [1:0] WR = 2'b10;

    int vectors = 0;
    int misses = 0;
    logic [15:0] rom [256];
    logic [7:0] model_pc;
    cyc_t exp_q[$];

    // Word memory: read data appears the cycle after a READ.
    always @(posedge clk)
        if (mem_cmd == RD) mdata <= rom[mem_addr];

    function automatic cyc_t cur();
        cyc_t c;
        c.readnum = readnum;   c.writenum = writenum;
        c.vsel = vsel;         c.asel = asel;
        c.bsel = bsel;         c.aluop = ALUop;
        c.shift = shift;       c.loada = loada;
        c.loadb = loadb;       c.loadc = loadc;
        c.loads = loads;       c.write = write;
        c.mem_cmd = mem_cmd;   c.mem_addr = mem_addr;
        c.halted = halted;     c.pc = PC;
        return c;
    endfunction

    function automatic cyc_t idle(input logic [7:0] p);
        cyc_t c = '0;
        c.mem_addr = p;
        c.pc = p;
        return c;
    endfunction

    task automatic check_cyc(input string name, input cyc_t exp);
        cyc_t got = cur();
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Expected cycle-by-cycle outputs of one instruction, from IF1 onward.
    task automatic model(input logic [15:0] ir, input logic [7:0] pc,
                         input logic [15:0] dp, input logic [2:0] st,
                         output logic [7:0] npc, output bit halt);
        cyc_t c;
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        logic [7:0] pc1, da;
        bit take;
        opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
        rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
        pc1 = pc + 8'd1;
        da = dp[7:0];
        npc = pc1;
        halt = 0;
        take = 0;
        exp_q.delete();
        c = idle(pc); c.mem_cmd = RD;
        exp_q.push_back(c);
        exp_q.push_back(c);
        exp_q.push_back(idle(pc));
        exp_q.push_back(idle(pc1));
        if (opc == 3'b110 && op == 2'b10) begin
            c = idle(pc1); c.vsel = 2'b10; c.writenum = rn; c.write = 1;
            exp_q.push_back(c);
        end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
            if (opc == 3'b101 && op != 2'b11) begin
                c = idle(pc1); c.readnum = rn; c.loada = 1;
                exp_q.push_back(c);
            end
            c = idle(pc1); c.readnum = rm; c.loadb = 1;
            exp_q.push_back(c);
            c = idle(pc1); c.shift = sh;
            if (opc == 3'b110) c.asel = 2'b01;
            else c.aluop = op;
            if (opc == 3'b101 && op == 2'b01) c.loads = 1;
            else c.loadc = 1;
            exp_q.push_back(c);
            if (!(opc == 3'b101 && op == 2'b01)) begin
                c = idle(pc1); c.writenum = rd; c.write = 1;
                exp_q.push_back(c);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && op == 2'b00) begin
            c = idle(pc1); c.readnum = rn; c.loada = 1;
            exp_q.push_back(c);
            c = idle(pc1); c.bsel = 2'b01; c.loadc = 1;
            exp_q.push_back(c);
            exp_q.push_back(idle(pc1));
            if (opc == 3'b011) begin
                c = idle(pc1); c.mem_cmd = RD; c.mem_addr = da;
                exp_q.push_back(c);
                c.vsel = 2'b01; c.writenum = rd; c.write = 1;
                exp_q.push_back(c);
            end else begin
                c = idle(pc1); c.readnum = rd; c.loadb = 1;
                exp_q.push_back(c);
                c = idle(pc1); c.asel = 2'b01; c.loadc = 1;
                exp_q.push_back(c);
                c = idle(pc1); c.mem_cmd = WR; c.mem_addr = da;
                exp_q.push_back(c);
            end
`ifdef CPU_BRANCH_EN
        end else if (opc == 3'b001 && rn <= 3'd4) begin
            case (rn)
                3'd0: take = 1;
                3'd1: take = st[2];
                3'd2: take = !st[2];
                3'd3: take = st[0] != st[1];
                default: take = (st[0] != st[1]) || st[2];
            endcase
            if (take) begin
                c = idle(pc1); c.asel = 2'b10; c.bsel = 2'b10; c.loadc = 1;
                exp_q.push_back(c);
                exp_q.push_back(idle(pc1));
                npc = da;
            end
`endif
        end else begin
            halt = 1;
            c = idle(pc1); c.halted = 1;
            repeat (20) exp_q.push_back(c);
        end
    endtask

    // Entered with the DUT sampled in IF1; leaves it in the next IF1.
    task automatic run_instr(input string tag, input logic [15:0] ir,
                             input logic [15:0] dp, input logic [2:0] st,
                             output int cycles);
        logic [7:0] npc;
        bit halt;
        rom[model_pc] = ir;
        datapath_out = dp;
        status_in = st;
        model(ir, model_pc, dp, st, npc, halt);
        cycles = -1;
        for (int k = 0; k < 40; k++) begin
            if (!halt && k >= 4 && mem_cmd == RD && mem_addr == PC) begin
                cycles = k;
                break;
            end
            if (halt && k == exp_q.size()) begin
                cycles = k;
                break;
            end
            if (k < exp_q.size()) begin
                check_cyc($sformatf("%s c%0d", tag, k), exp_q[k]);
            end else begin
                misses++;
                vectors++;
                $display("FAIL %s overrun: got cycle %0d expected %0d cycles", tag, k, exp_q.size());
                cycles = k;
                break;
            end
            if (k == 3) begin
                check_val({tag, " sximm8"}, sximm8, 16'($signed(ir[7:0])));
                check_val({tag, " sximm5"}, sximm5, 16'($signed(ir[4:0])));
            end
            @(posedge clk); #1;
        end
        if (!halt) begin
            check_val({tag, " cycles"}, 16'(cycles), 16'(exp_q.size()));
            model_pc = npc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        check_cyc("rst state", '0);
        check_val("rst sximm8", sximm8, 16'h0000);
        check_val("rst sximm5", sximm5, 16'h0000);
        @(posedge clk); #1;
        model_pc = 8'h00;
    endtask

    function automatic logic [15:0] rand_instr(input logic [7:0] pc);
        logic [15:0] ir;
        int kind;
`ifdef CPU_BRANCH_EN
        kind = $urandom_range(0, 8);
`else
        kind = $urandom_range(0, 7);
`endif
        ir = 16'($urandom);
        case (kind)
            0: ir[15:11] = 5'b11010;
            1: ir[15:11] = 5'b11000;
            2: ir[15:11] = 5'b10100;
            3: ir[15:11] = 5'b10101;
            4: ir[15:11] = 5'b10110;
            5: ir[15:11] = 5'b10111;
            6: ir[15:11] = 5'b01100;
            7: ir[15:11] = 5'b10000;
            default: begin
                ir[15:11] = 5'b00100;
                ir[10:8] = 3'($urandom_range(0, 4));
            end
        endcase
        return ir;
    endfunction

    vec_t tbl[$];
    logic [15:0] halts[$];
    logic [7:0] tb_base;
    logic [15:0] ir, dp;
    int cyc;

    initial begin
        reset = 1;
        mdata = 16'h0000;
        datapath_out = 16'h0000;
        status_in = 3'b000;
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

        tbl.push_back('{16'hD0FD, 16'h0000, 3'b000, 5, 8'h01});
        tbl.push_back('{16'hA148, 16'h0000, 3'b000, 8, 8'h02});
        tbl.push_back('{16'h6162, 16'h0012, 3'b000, 9, 8'h03});
        tbl.push_back('{16'h8162, 16'h0012, 3'b000, 10, 8'h04});
`ifdef CPU_BRANCH_EN
        tbl.push_back('{16'h2104, 16'h0009, 3'b100, 6, 8'h09});
        tbl.push_back('{16'h2104, 16'h0009, 3'b000, 4, 8'h0A});
        tb_base = 8'h0A;
`else
        tb_base = 8'h04;
`endif
        tbl.push_back('{16'hA948, 16'h0000, 3'b000, 7, tb_base + 8'd1});
        tbl.push_back('{16'hB148, 16'h0000, 3'b000, 8, tb_base + 8'd2});
        tbl.push_back('{16'hB948, 16'h0000, 3'b000, 7, tb_base + 8'd3});
        tbl.push_back('{16'hC021, 16'h0000, 3'b000, 7, tb_base + 8'd4});

        do_reset();
        foreach (tbl[i]) begin
            run_instr($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].dp, tbl[i].st, cyc);
            check_val($sformatf("tbl%0d ncyc", i), 16'(cyc), 16'(tbl[i].cycles));
            check_val($sformatf("tbl%0d npc", i), {8'h00, PC}, {8'h00, tbl[i].npc});
        end

        // Reset landing in the EX state of an ADD.
        rom[model_pc] = 16'hA148;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check_val("pre-reset ex loadc", {15'h0, loadc}, 16'h0001);
        #2 reset = 1;
        #1;
        check_cyc("async reset", '0);
        #2 reset = 0;
        @(posedge clk); #1;
        check_cyc("post-reset if1", '{mem_cmd: RD, default: '0});
        model_pc = 8'h00;

        for (int n = 0; n < 150; n++) begin
            ir = rand_instr(model_pc);
            dp = 16'($urandom);
            if (dp[7:0] == model_pc + 8'd1) dp[7] = ~dp[7];
            run_instr($sformatf("rnd%0d", n), ir, dp, 3'($urandom), cyc);
        end

        halts.push_back(16'hE000);
        halts.push_back(16'h0000);
        halts.push_back(16'h6800);
        halts.push_back(16'hD800);
`ifdef CPU_BRANCH_EN
        halts.push_back(16'h2504);
`else
        halts.push_back(16'h2104);
`endif
        foreach (halts[i]) begin
            do_reset();
            run_instr($sformatf("halt%04h", halts[i]), halts[i], 16'h0033, 3'b000, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
